ct_spsram_pipe: RTL and testbench

CT_SPSRAM_PIPE -- requirements
Module: ct_spsram_pipe

---
 rtl/ct_spsram_pipe.sv | 135 +++++++++++++
 tb/tb_ct_spsram_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_pipe.sv
// ct_spsram_pipe: single-port SRAM model with bit-masked writes and an optional
// output register. Define CT_SPSRAM_PIPE_INIT_EN to compile in the zeroing sweep.
module ct_spsram_pipe #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 52,
    parameter int OUT_REG    = 0
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  BUSY
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  w_busy;
    logic                  w_acc;
    logic                  w_rd;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_wmask;

`ifdef CT_SPSRAM_PIPE_INIT_EN
    typedef enum logic {INIT, READY} state_t;

    state_t                r_state;
    state_t                w_stateNxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cntNxt;
    logic                  w_sweepWe;

    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_cnt   <= w_cntNxt;
        end
    end

    // The counter freezes on the last address so READY is never left for INIT.
    always_comb begin
        w_stateNxt = r_state;
        w_cntNxt   = r_cnt;
        w_busy     = 1'b0;
        w_sweepWe  = 1'b0;
        case (r_state)
            INIT: begin
                w_busy    = 1'b1;
                w_sweepWe = cpurst_b;
                if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_stateNxt = READY;
                end else begin
                    w_cntNxt = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            READY: begin
                w_busy = 1'b0;
            end
            default: begin
                w_stateNxt = INIT;
                w_busy     = 1'b1;
            end
        endcase
    end
`else
    assign w_busy = 1'b0;
`endif

    assign BUSY  = w_busy;
    assign w_acc = cpurst_b & ~CEN & ~w_busy;
    assign w_rd  = w_acc & GWEN;

    always_comb begin
        w_we    = w_acc & ~GWEN;
        w_addr  = A;
        w_wdata = D;
        w_wmask = ~WEN;
`ifdef CT_SPSRAM_PIPE_INIT_EN
        if (w_sweepWe) begin
            w_we    = 1'b1;
            w_addr  = r_cnt;
            w_wdata = '0;
            w_wmask = '1;
        end
`endif
    end

    // The array has no reset; only the sweep (when present) clears it.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[w_addr] <= (r_mem[w_addr] & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            r_rdData <= '0;
        end else if (w_rd) begin
            r_rdData <= r_mem[A];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_outReg
            logic                  r_rdVld;
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge CLK) begin
                if (!cpurst_b) begin
                    r_rdVld <= 1'b0;
                    r_q     <= '0;
                end else begin
                    r_rdVld <= w_rd;
                    if (r_rdVld) begin
                        r_q <= r_rdData;
                    end
                end
            end

            assign Q = r_q;
        end else begin : g_noOutReg
            assign Q = r_rdData;
        end
    endgenerate

endmodule

// File: tb/tb_ct_spsram_pipe.sv
// Bench for ct_spsram_pipe: drives one OUT_REG=0 and one OUT_REG=1 instance in
// lockstep; a queue-based monitor checks read data at each instance's latency.
module tb_ct_spsram_pipe;
    localparam int AW = 4;
    localparam int DW = 52;

    logic          CLK = 1'b0;
    logic          cpurst_b = 1'b0;
    logic          CEN = 1'b1;
    logic          GWEN = 1'b1;
    logic [DW-1:0] WEN = '1;
    logic [AW-1:0] A = '0;
    logic [DW-1:0] D = '0;
    logic [DW-1:0] Q0, Q1;
    logic          BUSY0, BUSY1;

    logic          rdCheck = 1'b0;
    logic          v1 = 1'b0;
    logic          v2 = 1'b0;
    logic [DW-1:0] expQ0[$];
    logic [DW-1:0] expQ1[$];
    int            nAsserts = 0;
    int            nFail = 0;

    localparam logic [DW-1:0] V5   = 52'hA_BCDE_F012_3456;
    localparam logic [DW-1:0] V1   = 52'h1_1111_2222_3333;
    localparam logic [DW-1:0] V2   = 52'h2_4680_ACE1_3579;
    localparam logic [DW-1:0] VFF  = 52'h0_0000_0000_00FF;
    localparam logic [DW-1:0] JUNK = 52'h5_A5A5_C3C3_0F0F;

    ct_spsram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0)) u_dut0 (
        .CLK(CLK), .cpurst_b(cpurst_b), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
        .A(A), .D(D), .Q(Q0), .BUSY(BUSY0)
    );

    ct_spsram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) u_dut1 (
        .CLK(CLK), .cpurst_b(cpurst_b), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
        .A(A), .D(D), .Q(Q1), .BUSY(BUSY1)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nAsserts++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic cen, input logic gwen,
                                 input logic [DW-1:0] wen, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic chk);
        @(negedge CLK);
        cpurst_b = rstN;
        CEN      = cen;
        GWEN     = gwen;
        WEN      = wen;
        A        = a;
        D        = d;
        rdCheck  = chk;
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b1, 1'b1, '1, '0, '0, 1'b0);
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] wen);
        applyStimulus(1'b1, 1'b0, 1'b0, wen, a, d, 1'b0);
    endtask

    // Reads drive an all-enabled mask and junk data, which must be ignored.
    task automatic doRead(input logic [AW-1:0] a, input logic [DW-1:0] expected);
        expQ0.push_back(expected);
        expQ1.push_back(expected);
        applyStimulus(1'b1, 1'b0, 1'b1, '0, a, JUNK, 1'b1);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!BUSY0) break;
            n++;
            idle();
        end
    endtask

    always @(posedge CLK) begin
        v1 <= rdCheck & cpurst_b;
        v2 <= v1;
    end

    always @(negedge CLK) begin
        if (v1) begin
            if (expQ0.size() == 0) checkOutput("q0_unexpected", 64'(Q0), 64'hDEAD);
            else checkOutput("q0_read", 64'(Q0), 64'(expQ0.pop_front()));
        end
        if (v2) begin
            if (expQ1.size() == 0) checkOutput("q1_unexpected", 64'(Q1), 64'hDEAD);
            else checkOutput("q1_read", 64'(Q1), 64'(expQ1.pop_front()));
        end
    end

    initial begin
        int nBusy;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, '1, '0, '0, 1'b0);
        checkOutput("reset_q0", 64'(Q0), 64'h0);
        checkOutput("reset_q1", 64'(Q1), 64'h0);
`ifdef CT_SPSRAM_PIPE_INIT_EN
        checkOutput("reset_busy0", 64'(BUSY0), 64'h1);
        checkOutput("reset_busy1", 64'(BUSY1), 64'h1);
        idle();
        countBusy(nBusy);
        checkOutput("sweep_busy_cycles", 64'(nBusy), 64'd16);
        checkOutput("ready_busy1", 64'(BUSY1), 64'h0);
        for (int i = 0; i < 16; i++) doRead(AW'(i), '0);
        doWrite(4'd5, V5, '0);
`else
        checkOutput("reset_busy0", 64'(BUSY0), 64'h0);
        doWrite(4'd5, V5, '0);
        checkOutput("first_cycle_busy0", 64'(BUSY0), 64'h0);
        checkOutput("first_cycle_busy1", 64'(BUSY1), 64'h0);
`endif
        doRead(4'd5, V5);
        idle();
        idle();

        doWrite(4'd3, '0, '0);
        doWrite(4'd3, '1, ~VFF);
        doRead(4'd3, VFF);
        doWrite(4'd1, V1, '0);
        doWrite(4'd2, V2, '0);
        doRead(4'd1, V1);
        doRead(4'd2, V2);
        doRead(4'd3, VFF);
        for (int i = 0; i < 3; i++) idle();
        checkOutput("hold_idle_q0", 64'(Q0), 64'(VFF));
        checkOutput("hold_idle_q1", 64'(Q1), 64'(VFF));
        doWrite(4'd7, JUNK, '0);
        idle();
        idle();
        checkOutput("hold_write_q0", 64'(Q0), 64'(VFF));
        checkOutput("hold_write_q1", 64'(Q1), 64'(VFF));
        doRead(4'd5, V5);
        doRead(4'd5, V5);
        doRead(4'd7, JUNK);
        for (int i = 0; i < 3; i++) idle();
`ifndef CT_SPSRAM_PIPE_INIT_EN
        checkOutput("no_init_busy0", 64'(BUSY0), 64'h0);
`endif

`ifdef CT_SPSRAM_PIPE_INIT_EN
        // Abort a sweep at address 7, then try a write while the restart runs.
        applyStimulus(1'b0, 1'b1, 1'b1, '1, '0, '0, 1'b0);
        idle();
        for (int i = 0; i < 6; i++) idle();
        checkOutput("midsweep_busy0", 64'(BUSY0), 64'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, '1, '0, '0, 1'b0);
        doWrite(4'd9, '1, '0);
        countBusy(nBusy);
        checkOutput("restart_busy_cycles", 64'(nBusy), 64'd16);
        checkOutput("restart_q0", 64'(Q0), 64'h0);
        checkOutput("restart_q1", 64'(Q1), 64'h0);
        doRead(4'd9, '0);
        doRead(4'd5, '0);
        doRead(4'd3, '0);
        for (int i = 0; i < 3; i++) idle();
`endif

        checkOutput("q0_drained", 64'(expQ0.size()), 64'd0);
        checkOutput("q1_drained", 64'(expQ1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
